// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the servo sequencer.
//   ch_state_e    : per-channel sequencer state
//   cmd_e         : command kind, encoded as {instr_active, instr_mode}
//   decode_cmd    : maps the two instruction flag bits onto cmd_e
//   DEFAULT_POS_W : default position width
package servo_pkg;

  localparam int DEFAULT_POS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MANUAL  = 2'd1,
    ST_EXTEND  = 2'd2,
    ST_RETRACT = 2'd3
  } ch_state_e;

  // Encoding is {active, mode} so the decode is a plain cast.
  typedef enum logic [1:0] {
    CMD_STOP   = 2'b00,
    CMD_SETPOS = 2'b01,
    CMD_AUTO   = 2'b10,
    CMD_MANUAL = 2'b11
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic active, input logic mode);
    return cmd_e'({active, mode});
  endfunction

endpackage

// File: rtl/seq_channel.sv
// seq_channel: one servo channel of the sequencer.
// Holds the channel state machine, dwell counter, target and commanded position,
// and the programmable extended/retracted end positions.
// Optional feature macro: SERVO_SEQ_SLEW_LIMIT_EN (position slews toward target
// one count per slew_tick instead of jumping).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   cmd_valid    : a non-STOP command addressed to this channel
//   cmd          : decoded command kind
//   cmd_sel      : SETPOS select, 1 = extended, 0 = retracted
//   cmd_value    : command position value
//   stop         : global stop, applies to every channel
//   slew_tick    : shared prescaler tick (slew build only)
//   pos          : commanded position (registered)
//   enable       : servo-driver enable (registered)
//   busy         : auto sequence (EXTEND or RETRACT) in progress
import servo_pkg::*;

module seq_channel #(
  parameter int POS_W       = DEFAULT_POS_W,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  cmd_e             cmd,
  input  logic             cmd_sel,
  input  logic [POS_W-1:0] cmd_value,
  input  logic             stop,
`ifdef SERVO_SEQ_SLEW_LIMIT_EN
  input  logic             slew_tick,
`endif
  output logic [POS_W-1:0] pos,
  output logic             enable,
  output logic             busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  ch_state_e        state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [POS_W-1:0] target_reg, target_next;
  logic [POS_W-1:0] pos_reg,    pos_next;
  logic [POS_W-1:0] ext_reg,    ext_next;
  logic [POS_W-1:0] ret_reg,    ret_next;
  logic             enable_reg, enable_next;
  logic             at_target;

  assign at_target = (pos_reg == target_reg);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    target_next = target_reg;
    ext_next    = ext_reg;
    ret_next    = ret_reg;
    enable_next = enable_reg;

    // Dwell: count only while parked at the target, so with slew limiting the
    // hold time starts on arrival.
    case (state_reg)
      ST_EXTEND: begin
        if (at_target) begin
          if (cnt_reg == CNT_LAST) begin
            state_next  = ST_RETRACT;
            target_next = ret_reg;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_RETRACT: begin
        if (at_target) begin
          if (cnt_reg == CNT_LAST) begin
            state_next  = ST_IDLE;
            enable_next = 1'b0;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (stop) begin
      // Freeze the target at the current position so a slewing channel halts.
      state_next  = ST_IDLE;
      enable_next = 1'b0;
      cnt_next    = '0;
      target_next = pos_reg;
    end else if (cmd_valid) begin
      case (cmd)
        CMD_MANUAL: begin
          state_next  = ST_MANUAL;
          target_next = cmd_value;
          enable_next = 1'b1;
          cnt_next    = '0;
        end
        CMD_AUTO: begin
          state_next  = ST_EXTEND;
          target_next = ext_reg;
          enable_next = 1'b1;
          cnt_next    = '0;
        end
        CMD_SETPOS: begin
          if (cmd_sel) ext_next = cmd_value;
          else         ret_next = cmd_value;
        end
        default: ;
      endcase
    end
  end

`ifdef SERVO_SEQ_SLEW_LIMIT_EN
  // Step toward the new target so a STOP (target frozen) never moves.
  always_comb begin
    pos_next = pos_reg;
    if (slew_tick) begin
      if (pos_reg < target_next)      pos_next = pos_reg + POS_W'(1);
      else if (pos_reg > target_next) pos_next = pos_reg - POS_W'(1);
    end
  end
`else
  // Position follows the target directly, giving one-cycle command latency.
  assign pos_next = target_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      target_reg <= '0;
      pos_reg    <= '0;
      ext_reg    <= '1;
      ret_reg    <= '0;
      enable_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      target_reg <= target_next;
      pos_reg    <= pos_next;
      ext_reg    <= ext_next;
      ret_reg    <= ret_next;
      enable_reg <= enable_next;
    end
  end

  assign pos    = pos_reg;
  assign enable = enable_reg;
  assign busy   = (state_reg == ST_EXTEND) || (state_reg == ST_RETRACT);

endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: multi-channel servo position sequencer.
// Decodes one instruction per cycle and routes it to NUM_CH seq_channel
// instances; STOP is broadcast to all channels.
// Optional feature macro: SERVO_SEQ_SLEW_LIMIT_EN (adds a shared prescaler
// producing a slew tick every SLEW_DIV cycles).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   instr_valid  : qualifies the instr_* fields for one cycle
//   instr_active : 1 = motion command, 0 = configuration/stop
//   instr_mode   : 1 = maintenance/config, 0 = auto/stop
//   instr_sel    : SETPOS end-position select, 1 = extended, 0 = retracted
//   instr_ch     : target channel (out-of-range indices are ignored)
//   instr_value  : position value
//   pos_out      : per-channel commanded position, channel 0 in LSBs
//   enable_out   : per-channel driver enable
//   busy         : per-channel auto sequence in progress
import servo_pkg::*;

module servo_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = DEFAULT_POS_W,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SLEW_DIV    = 50000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  input  logic                    instr_active,
  input  logic                    instr_mode,
  input  logic                    instr_sel,
  input  logic [CH_W-1:0]         instr_ch,
  input  logic [POS_W-1:0]        instr_value,
  output logic [NUM_CH*POS_W-1:0] pos_out,
  output logic [NUM_CH-1:0]       enable_out,
  output logic [NUM_CH-1:0]       busy
);

  cmd_e cmd;
  logic stop;

  assign cmd  = decode_cmd(instr_active, instr_mode);
  assign stop = instr_valid && (cmd == CMD_STOP);

`ifdef SERVO_SEQ_SLEW_LIMIT_EN
  localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

  logic [DIV_W-1:0] presc_reg;
  logic             slew_tick;

  assign slew_tick = (presc_reg == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          presc_reg <= '0;
    else if (slew_tick) presc_reg <= '0;
    else                presc_reg <= presc_reg + DIV_W'(1);
  end
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             ch_cmd_valid;
      logic [POS_W-1:0] ch_pos;

      // An index that matches no instance (instr_ch >= NUM_CH) selects nothing.
      assign ch_cmd_valid = instr_valid && (cmd != CMD_STOP) &&
                            (instr_ch == CH_W'(gi));

      seq_channel #(
        .POS_W       (POS_W),
        .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (ch_cmd_valid),
        .cmd       (cmd),
        .cmd_sel   (instr_sel),
        .cmd_value (instr_value),
        .stop      (stop),
`ifdef SERVO_SEQ_SLEW_LIMIT_EN
        .slew_tick (slew_tick),
`endif
        .pos       (ch_pos),
        .enable    (enable_out[gi]),
        .busy      (busy[gi])
      );

      assign pos_out[gi*POS_W +: POS_W] = ch_pos;
    end
  endgenerate

endmodule
